loadable_counter: RTL and testbench



---
 rtl/loadable_counter_pkg.sv | 9 +
 rtl/loadable_counter_next.sv | 40 ++++
 rtl/loadable_counter.sv | 37 +++
 tb/tb_loadable_counter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/loadable_counter_pkg.sv
// rtl/loadable_counter_pkg.sv - shared constants for the loadable up/down counter
package loadable_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEFAULT_WIDTH = 4;

endpackage : loadable_counter_pkg

// File: rtl/loadable_counter_next.sv
// rtl/loadable_counter_next.sv - combinational next-count step; LOADABLE_COUNTER_SAT_EN selects saturate instead of wrap
module loadable_counter_next
  import loadable_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [0:WIDTH-1] count,
  input  logic             opnd,
  output logic [0:WIDTH-1] next_count
);

  localparam logic [0:WIDTH-1] ALL_ONES  = '1;
  localparam logic [0:WIDTH-1] ALL_ZEROS = '0;
  localparam logic [0:WIDTH-1] ONE       = WIDTH'(1);

  logic [0:WIDTH-1] count_inc;
  logic [0:WIDTH-1] count_dec;

  // Index 0 is the MSB, so the vector's numeric value is the ordinary unsigned count.
  assign count_inc = count + ONE;
  assign count_dec = count - ONE;

  always_comb begin
    next_count = count;
`ifdef LOADABLE_COUNTER_SAT_EN
    if (opnd == DIR_UP) begin
      next_count = (count == ALL_ONES) ? ALL_ONES : count_inc;
    end else begin
      next_count = (count == ALL_ZEROS) ? ALL_ZEROS : count_dec;
    end
`else
    if (opnd == DIR_UP) begin
      next_count = count_inc;
    end else begin
      next_count = count_dec;
    end
`endif
  end

endmodule : loadable_counter_next

// File: rtl/loadable_counter.sv
// rtl/loadable_counter.sv - up/down counter preloaded from load while rst is high; LOADABLE_COUNTER_SAT_EN saturates
module loadable_counter
  import loadable_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] load,
  input  logic             opnd,
  output logic [0:WIDTH-1] count
);

  logic [0:WIDTH-1] next_count;
  logic [0:WIDTH-1] count_d;

  loadable_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count      (count),
    .opnd       (opnd),
    .next_count (next_count)
  );

  // rst doubles as the load strobe, so there is no fixed reset constant.
  always_comb begin
    count_d = next_count;
    if (rst) begin
      count_d = load;
    end
  end

  always_ff @(posedge clk) begin
    count <= count_d;
  end

endmodule : loadable_counter

// File: tb/tb_loadable_counter.sv
// tb/tb_loadable_counter.sv - scoreboard bench for loadable_counter with random stimulus and arithmetic reference model
module tb_loadable_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst;
  logic [0:W-1] load;
  logic         opnd;
  logic [0:W-1] count;

  int checks;
  int fails;
  int model;

  logic [W-1:0] sb[$];

  loadable_counter #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .opnd  (opnd),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic straight from the counting rules.
  function automatic int ref_next(input int cur, input bit r, input int ld, input bit up);
    if (r) return ld;
`ifdef LOADABLE_COUNTER_SAT_EN
    if (up) return (cur == MOD - 1) ? MOD - 1 : cur + 1;
    return (cur == 0) ? 0 : cur - 1;
`else
    if (up) return (cur + 1) % MOD;
    return (cur + MOD - 1) % MOD;
`endif
  endfunction

  task automatic step(input bit r, input int ld, input bit up);
    @(negedge clk);
    rst  = r;
    load = W'(ld);
    opnd = up;
    model = ref_next(model, r, ld, up);
    sb.push_back(W'(model));
  endtask

  // Monitor: count is presented every edge; compare against the oldest expectation.
  initial begin
    logic [W-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        checks++;
        if (count !== exp) begin
          fails++;
          $display("FAIL count check %0d at %0t: got %b expected %b", checks, $time, count, exp);
        end
      end
    end
  end

  initial begin
    checks = 0;
    fails  = 0;
    model  = 0;
    rst    = 1'b1;
    load   = '0;
    opnd   = 1'b1;

    // load 0101 then up
    step(1, 5, 1);
    repeat (3) step(0, $urandom_range(0, MOD - 1), 1);
    // load 0101 then down
    step(1, 5, 0);
    repeat (3) step(0, $urandom_range(0, MOD - 1), 0);
    // wrap / saturate up from 1110
    step(1, 14, 1);
    repeat (3) step(0, 0, 1);
    // wrap / saturate down from 0001
    step(1, 1, 0);
    repeat (3) step(0, 15, 0);
    // reset mid-count at 1010 with load 0011
    step(1, 9, 1);
    step(0, 7, 1);
    step(1, 3, 1);
    repeat (2) step(0, 12, 1);
    // direction change at 0110
    step(1, 5, 1);
    step(0, 5, 1);
    step(0, 5, 0);
    step(0, 11, 0);
    // reset held several edges, load changing
    step(1, 7, 0);
    step(1, 8, 1);
    step(0, 2, 1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) == 0), $urandom_range(0, MOD - 1), $urandom_range(0, 1));
    end

    begin
      int budget;
      budget = 10;
      while (sb.size() > 0 && budget > 0) begin
        @(posedge clk);
        #2;
        budget--;
      end
      if (sb.size() > 0) begin
        fails++;
        $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_loadable_counter
